// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file: three sources share one write port
// (fixed priority LSU > MDU > ALU with aging), plus a pending-write scoreboard for stalls.
module rf_wb_arbiter #(
    parameter int AGE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wd,
    input  logic        mdu_req,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_wd,
    input  logic        alu_req,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_wd,
    output logic        lsu_gnt,
    output logic        mdu_gnt,
    output logic        alu_gnt,
    input  logic        alloc_en,
    input  logic [4:0]  alloc_rd,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic        raw_stall,
    output logic        waw_stall,
    output logic        RFWr,
    output logic [4:0]  WBSel,
    output logic [31:0] WD,
    output logic [31:0] busy,
    output logic        sb_err
);

    // Source index doubles as fixed priority: 0 = LSU, 1 = MDU, 2 = ALU.
    localparam int         NSRC    = 3;
    localparam logic [1:0] AGE_SAT = 2'd3;
    localparam logic [1:0] AGE_LIM = 2'(AGE_LIMIT);

    logic [NSRC-1:0] req;
    logic [4:0]      rd  [NSRC];
    logic [31:0]     wd  [NSRC];
    logic [1:0]      age [NSRC];

    logic [NSRC-1:0] real_req;
    logic [NSRC-1:0] zero_req;
    logic [NSRC-1:0] win;
    logic [NSRC-1:0] gnt;
    logic            win_any;
    logic [4:0]      win_rd;
    logic [31:0]     win_wd;
    logic            aged_any;
    logic            found;
    logic [1:0]      best_age;

    logic [31:0]     clr_vec;
    logic [31:0]     set_vec;
    logic [31:0]     busy_next;
    logic            alloc_hit;
    logic            alloc_ok;
    logic            alloc_bad;

    assign req   = {alu_req, mdu_req, lsu_req};
    assign rd[0] = lsu_rd;
    assign rd[1] = mdu_rd;
    assign rd[2] = alu_rd;
    assign wd[0] = lsu_wd;
    assign wd[1] = mdu_wd;
    assign wd[2] = alu_wd;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            real_req[i] = req[i] && (rd[i] != 5'd0);
            zero_req[i] = req[i] && (rd[i] == 5'd0);
        end
    end

    // Normal mode keeps the first real requester; aged mode keeps the strictly oldest,
    // so ties fall back to priority order.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        win      = '0;
        win_rd   = '0;
        win_wd   = '0;
        aged_any = 1'b0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (real_req[i] && (age[i] >= AGE_LIM)) begin
                aged_any = 1'b1;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (real_req[i] && (!found || (aged_any && (age[i] > best_age)))) begin
                win      = '0;
                win[i]   = 1'b1;
                found    = 1'b1;
                best_age = age[i];
                win_rd   = rd[i];
                win_wd   = wd[i];
            end
        end
        if (rst) begin
            win = '0;
        end
    end

    assign win_any = |win;
    assign gnt     = rst ? '0 : (win | zero_req);
    assign lsu_gnt = gnt[0];
    assign mdu_gnt = gnt[1];
    assign alu_gnt = gnt[2];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (gnt[i] || !req[i]) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_SAT) begin
                    age[i] <= age[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RFWr  <= 1'b0;
            WBSel <= '0;
            WD    <= '0;
        end else begin
            RFWr <= win_any;
            if (win_any) begin
                WBSel <= win_rd;
                WD    <= win_wd;
            end
        end
    end

    // A register being written back this edge may be re-allocated; the set wins.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (RFWr) begin
            clr_vec[WBSel] = 1'b1;
        end
        alloc_hit = alloc_en && (alloc_rd != 5'd0);
        alloc_ok  = alloc_hit && (!busy[alloc_rd] || clr_vec[alloc_rd]);
        alloc_bad = alloc_hit && busy[alloc_rd] && !clr_vec[alloc_rd];
        if (alloc_ok) begin
            set_vec[alloc_rd] = 1'b1;
        end
        busy_next = ((busy & ~clr_vec) | set_vec) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: busy is a flop vector rather than a RAM, so it is cleared with the rest of
        // the state; the register file contents themselves are never reset.
        if (rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (alloc_bad) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign raw_stall = ((A1 != 5'd0) && busy[A1]) || ((A2 != 5'd0) && busy[A2]);
    assign waw_stall = (alloc_rd != 5'd0) && busy[alloc_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a cycle model compared on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_rf_wb_arbiter;

    localparam int AGE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0, mdu_req = 1'b0, alu_req = 1'b0;
    logic [4:0]  lsu_rd = '0, mdu_rd = '0, alu_rd = '0;
    logic [31:0] lsu_wd = '0, mdu_wd = '0, alu_wd = '0;
    logic        alloc_en = 1'b0;
    logic [4:0]  alloc_rd = '0, A1 = '0, A2 = '0;
    logic        lsu_gnt, mdu_gnt, alu_gnt;
    logic        raw_stall, waw_stall, RFWr, sb_err;
    logic [4:0]  WBSel;
    logic [31:0] WD, busy;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int wait_cycles;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .mdu_req(mdu_req), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
        .alu_req(alu_req), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .lsu_gnt(lsu_gnt), .mdu_gnt(mdu_gnt), .alu_gnt(alu_gnt),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .A1(A1), .A2(A2),
        .raw_stall(raw_stall), .waw_stall(waw_stall),
        .RFWr(RFWr), .WBSel(WBSel), .WD(WD), .busy(busy), .sb_err(sb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the registered outputs must show after the most recent edge.
    int        m_age [3];
    bit [31:0] m_busy = '0;
    bit        m_rfwr = 1'b0;
    bit [4:0]  m_wbsel = '0;
    bit [31:0] m_wd = '0;
    bit        m_err = 1'b0;

    always @(negedge clk) begin : model
        bit        r [3];
        bit [4:0]  d [3];
        bit [31:0] w [3];
        bit        g [3];
        int        cand [$];
        int        winner, max_age, clr;
        bit        do_set;

        r = '{lsu_req, mdu_req, alu_req};
        d = '{lsu_rd, mdu_rd, alu_rd};
        w = '{lsu_wd, mdu_wd, alu_wd};
        g = '{1'b0, 1'b0, 1'b0};
        winner = -1;
        cand.delete();
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (r[i] && d[i] == 0) g[i] = 1'b1;
                if (r[i] && d[i] != 0) cand.push_back(i);
            end
            if (cand.size() > 0) begin
                max_age = 0;
                foreach (cand[k]) if (m_age[cand[k]] > max_age) max_age = m_age[cand[k]];
                winner = cand[0];
                if (max_age >= AGE_LIMIT) begin
                    foreach (cand[k]) begin
                        if (m_age[cand[k]] == max_age) begin
                            winner = cand[k];
                            break;
                        end
                    end
                end
                g[winner] = 1'b1;
            end
        end

        if (checking) begin
            check("lsu_gnt", lsu_gnt, g[0]);
            check("mdu_gnt", mdu_gnt, g[1]);
            check("alu_gnt", alu_gnt, g[2]);
            check("raw_stall", raw_stall,
                  ((A1 != 0) && m_busy[A1]) || ((A2 != 0) && m_busy[A2]));
            check("waw_stall", waw_stall, (alloc_rd != 0) && m_busy[alloc_rd]);
            check("RFWr", RFWr, m_rfwr);
            check("WBSel", WBSel, m_wbsel);
            check("WD", WD, m_wd);
            check("busy", busy, m_busy);
            check("sb_err", sb_err, m_err);
        end

        if (rst) begin
            m_busy = '0; m_rfwr = 1'b0; m_wbsel = '0; m_wd = '0; m_err = 1'b0;
            for (int i = 0; i < 3; i++) m_age[i] = 0;
        end else begin
            clr    = m_rfwr ? int'(m_wbsel) : 0;
            do_set = 1'b0;
            if (alloc_en && alloc_rd != 0) begin
                if (m_busy[alloc_rd] && clr != int'(alloc_rd)) m_err = 1'b1;
                else do_set = 1'b1;
            end
            if (clr != 0) m_busy[clr] = 1'b0;
            if (do_set) m_busy[alloc_rd] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (g[i] || !r[i]) m_age[i] = 0;
                else if (m_age[i] < 3) m_age[i] = m_age[i] + 1;
            end
            m_rfwr = (winner >= 0);
            if (winner >= 0) begin
                m_wbsel = d[winner];
                m_wd    = w[winner];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_age[i] = 0;
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;

        // Single write to x5
        alloc_en = 1'b1; alloc_rd = 5'd5;
        #1 check("t1_waw_free", waw_stall, 1'b0);
        tick();
        alloc_en = 1'b0;
        alu_req = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF; A1 = 5'd5;
        #1 check("t1_alu_gnt", alu_gnt, 1'b1);
        check("t1_busy5_pend", busy[5], 1'b1);
        check("t1_raw_pend", raw_stall, 1'b1);
        tick();
        alu_req = 1'b0;
        #1 check("t1_rfwr", RFWr, 1'b1);
        check("t1_wbsel", WBSel, 32'd5);
        check("t1_wd", WD, 32'hDEADBEEF);
        check("t1_busy5_wr", busy[5], 1'b1);
        check("t1_raw_wr", raw_stall, 1'b1);
        tick();
        #1 check("t1_busy5_done", busy[5], 1'b0);
        check("t1_raw_done", raw_stall, 1'b0);
        A1 = 5'd0;

        // Fixed priority
        tick();
        lsu_req = 1'b1; lsu_rd = 5'd1; lsu_wd = 32'h11;
        mdu_req = 1'b1; mdu_rd = 5'd2; mdu_wd = 32'h22;
        alu_req = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
        #1 check("t2_lsu_first", {lsu_gnt, mdu_gnt, alu_gnt}, 3'b100);
        tick();
        lsu_req = 1'b0;
        #1 check("t2_mdu_second", {lsu_gnt, mdu_gnt, alu_gnt}, 3'b010);
        check("t2_wbsel1", WBSel, 32'd1);
        tick();
        mdu_req = 1'b0;
        #1 check("t2_alu_third", {lsu_gnt, mdu_gnt, alu_gnt}, 3'b001);
        check("t2_wbsel2", WBSel, 32'd2);
        tick();
        alu_req = 1'b0;
        #1 check("t2_wbsel3", WBSel, 32'd3);
        check("t2_wd3", WD, 32'h33);

        // Aging: LSU keeps winning until MDU reaches AGE_LIMIT
        tick();
        lsu_req = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'h100;
        mdu_req = 1'b1; mdu_rd = 5'd7;  mdu_wd = 32'h77;
        wait_cycles = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (mdu_gnt) begin
                wait_cycles = k;
                check("t3_lsu_blocked", lsu_gnt, 1'b0);
                break;
            end
            tick();
            lsu_rd = 5'(10 + k); lsu_wd = 32'h100 + 32'(k);
        end
        check("t3_mdu_wait", wait_cycles, 32'd4);
        tick();
        lsu_req = 1'b0; mdu_req = 1'b0;
        #1 check("t3_wbsel7", WBSel, 32'd7);
        check("t3_wd", WD, 32'h77);

        // Zero destination alongside a real write
        tick();
        alu_req = 1'b1; alu_rd = 5'd0; alu_wd = 32'h5;
        lsu_req = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h99;
        #1 check("t4_both_gnt", {lsu_gnt, alu_gnt}, 2'b11);
        tick();
        alu_req = 1'b0; lsu_req = 1'b0;
        #1 check("t4_wbsel9", WBSel, 32'd9);
        check("t4_busy", busy, 32'h0);
        tick();
        #1 check("t4_no_extra_wr", RFWr, 1'b0);

        // Scoreboard edges on x4
        alloc_en = 1'b1; alloc_rd = 5'd4;
        tick();
        alloc_en = 1'b0;
        lsu_req = 1'b1; lsu_rd = 5'd4; lsu_wd = 32'h44;
        #1 check("t5_lsu_gnt", lsu_gnt, 1'b1);
        tick();
        lsu_req = 1'b0;
        alloc_en = 1'b1; alloc_rd = 5'd4;
        #1 check("t5_clear_edge", {RFWr, WBSel}, {1'b1, 5'd4});
        check("t5_err_before", sb_err, 1'b0);
        tick();
        #1 check("t5_busy4_kept", busy[4], 1'b1);
        check("t5_waw", waw_stall, 1'b1);
        check("t5_no_err", sb_err, 1'b0);
        tick();
        alloc_en = 1'b0;
        #1 check("t5_err_set", sb_err, 1'b1);
        check("t5_busy4_still", busy[4], 1'b1);

        // Reset mid-operation
        tick();
        lsu_req = 1'b1; lsu_rd = 5'd13; lsu_wd = 32'h13;
        tick();
        lsu_req = 1'b0;
        rst = 1'b1;
        mdu_req = 1'b1; mdu_rd = 5'd12; mdu_wd = 32'h1212;
        #1 check("t6_gnt_in_rst", {lsu_gnt, mdu_gnt, alu_gnt}, 3'b000);
        check("t6_rfwr_pre", RFWr, 1'b1);
        check("t6_busy_pre", busy, 32'h10);
        tick();
        rst = 1'b0;
        #1 check("t6_rfwr_post", RFWr, 1'b0);
        check("t6_busy_post", busy, 32'h0);
        check("t6_err_post", sb_err, 1'b0);
        check("t6_mdu_regnt", mdu_gnt, 1'b1);
        tick();
        mdu_req = 1'b0;
        #1 check("t6_wr", {RFWr, WBSel, WD}, {1'b1, 5'd12, 32'h1212});

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
